// File: rtl/mips31_pkg.sv
// Shared types and constants for the EXE->MEM load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mips31_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    localparam logic [5:0] OPC_LW = 6'b100011;
    localparam logic [5:0] OPC_SW = 6'b101011;

    // Opcode bits that separate memory ops from everything else, and stores from loads
    localparam int INSTR_MEMOP_BIT = 31;
    localparam int INSTR_STORE_BIT = 29;

    // Write-back mux select encodings
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC8 = 2'd2;

    function automatic logic is_memop(input logic [31:0] instr);
        return instr[INSTR_MEMOP_BIT];
    endfunction

    function automatic logic is_store(input logic [31:0] instr);
        return instr[INSTR_MEMOP_BIT] & instr[INSTR_STORE_BIT];
    endfunction

endpackage

// File: rtl/exe_mem_lsu_watchdog.sv
// Busy-cycle counter that flags an access which has been outstanding too long.
// Latency: expire is combinational in the MAX_WAIT-th enabled cycle.
// Backpressure: none; clear has priority over enable.
module lsu_watchdog #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LAST_CNT = 16'(MAX_WAIT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Count enabled cycles; restart whenever the access resolves
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Fires in the cycle the count would reach MAX_WAIT, so busy lasts exactly MAX_WAIT cycles
    always_comb begin
        expire = enable && (cnt_q == LAST_CNT);
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/exe_mem_lsu.sv
// EXE->MEM pipeline register with a req/gnt/rvalid data-memory handshake for lw/sw.
// Latency: 1 cycle for non-memory ops; memory ops add 1+ cycles until gnt/rvalid or watchdog abort.
// Backpressure: mem_busy stalls the pipeline while an access is outstanding; ena/flush ignored then.
module exe_mem_lsu
    import mips31_pkg::*;
#(
    parameter int unsigned MAX_WAIT  = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ena,
    input  logic        flush,
    input  logic [31:0] exe_instr_in,
    input  logic [31:0] exe_pc_in,
    input  logic [31:0] exe_alu_result_in,
    input  logic [31:0] exe_GPR_rt_in,
    input  logic        exe_GPR_we_in,
    input  logic [4:0]  exe_GPR_waddr_in,
    input  logic [1:0]  exe_GPR_wdata_select_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_busy,
    output logic [31:0] mem_instr_out,
    output logic [31:0] mem_pc_out,
    output logic [31:0] mem_alu_result_out,
    output logic [31:0] mem_dmem_rdata_out,
    output logic        mem_GPR_we,
    output logic [4:0]  mem_GPR_waddr,
    output logic [1:0]  mem_GPR_wdata_select,
    output logic        mem_addr_err,
    output logic        mem_timeout
);

    lsu_state_t  state_q,    state_d;
    logic [31:0] instr_q,    instr_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] result_q,   result_d;
    logic [31:0] rt_q,       rt_d;
    logic [31:0] rdata_q,    rdata_d;
    logic        gpr_we_q,   gpr_we_d;
    logic        we_pend_q,  we_pend_d;
    logic [4:0]  waddr_q,    waddr_d;
    logic [1:0]  sel_q,      sel_d;
    logic        addr_err_q, addr_err_d;
    logic        timeout_q,  timeout_d;

    logic idle;
    logic capture;
    logic bubble;
    logic misaligned;
    logic start_access;
    logic cur_store;
    logic load_done;
    logic store_done;
    logic abort;
    logic wd_expire;

    // Pipeline events; completion always wins over a simultaneous watchdog expiry
    always_comb begin
        idle         = (state_q == IDLE);
        bubble       = idle && flush;
        capture      = idle && !flush && ena;
        misaligned   = |exe_alu_result_in[1:0];
        start_access = capture && is_memop(exe_instr_in) && !misaligned;
        cur_store    = is_store(instr_q);
        store_done   = (state_q == REQ) && dmem_gnt && cur_store;
        load_done    = ((state_q == REQ) && dmem_gnt && !cur_store && dmem_rvalid) ||
                       ((state_q == WAIT) && dmem_rvalid);
        abort        = wd_expire && !load_done && !store_done;
    end

    // Next-state logic for the access sequencer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_access) state_d = REQ;
            REQ: begin
                if (store_done || load_done || abort) begin
                    state_d = IDLE;
                end else if (dmem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: if (load_done || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pipeline register contents: bubble, capture, load return and abort
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        result_d   = result_q;
        rt_d       = rt_q;
        rdata_d    = rdata_q;
        gpr_we_d   = gpr_we_q;
        we_pend_d  = we_pend_q;
        waddr_d    = waddr_q;
        sel_d      = sel_q;
        addr_err_d = 1'b0;
        timeout_d  = timeout_q;
        if (bubble) begin
            instr_d   = '0;
            pc_d      = '0;
            result_d  = '0;
            rt_d      = '0;
            rdata_d   = '0;
            gpr_we_d  = 1'b0;
            we_pend_d = 1'b0;
            waddr_d   = '0;
            sel_d     = '0;
        end else if (capture) begin
            instr_d    = exe_instr_in;
            pc_d       = exe_pc_in;
            result_d   = exe_alu_result_in;
            rt_d       = exe_GPR_rt_in;
            we_pend_d  = exe_GPR_we_in;
            waddr_d    = exe_GPR_waddr_in;
            sel_d      = exe_GPR_wdata_select_in;
            // Memory ops hold write enable low until the load data is in hand
            gpr_we_d   = is_memop(exe_instr_in) ? 1'b0 : exe_GPR_we_in;
            addr_err_d = is_memop(exe_instr_in) && misaligned;
        end
        if (load_done) begin
            rdata_d  = dmem_rdata;
            gpr_we_d = we_pend_q;
        end
        if (abort) begin
            rdata_d   = ERR_RDATA;
            gpr_we_d  = 1'b0;
            timeout_d = 1'b1;
        end
    end

    // Memory port and stall outputs; request fields come straight from the captured registers
    always_comb begin
        mem_busy   = (state_q != IDLE);
        dmem_req   = (state_q == REQ);
        dmem_we    = dmem_req && cur_store;
        dmem_addr  = {result_q[31:2], 2'b00};
        dmem_wdata = rt_q;
    end

    // Registered MEM-stage outputs
    always_comb begin
        mem_instr_out        = instr_q;
        mem_pc_out           = pc_q;
        mem_alu_result_out   = result_q;
        mem_dmem_rdata_out   = rdata_q;
        mem_GPR_we           = gpr_we_q;
        mem_GPR_waddr        = waddr_q;
        mem_GPR_wdata_select = sel_q;
        mem_addr_err         = addr_err_q;
        mem_timeout          = timeout_q;
    end

    lsu_watchdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_d == IDLE),
        .enable (state_q != IDLE),
        .expire (wd_expire)
    );

    // State and pipeline registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            pc_q       <= '0;
            result_q   <= '0;
            rt_q       <= '0;
            rdata_q    <= '0;
            gpr_we_q   <= 1'b0;
            we_pend_q  <= 1'b0;
            waddr_q    <= '0;
            sel_q      <= '0;
            addr_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            result_q   <= result_d;
            rt_q       <= rt_d;
            rdata_q    <= rdata_d;
            gpr_we_q   <= gpr_we_d;
            we_pend_q  <= we_pend_d;
            waddr_q    <= waddr_d;
            sel_q      <= sel_d;
            addr_err_q <= addr_err_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_exe_mem_lsu.sv
// Self-checking bench for exe_mem_lsu with a transaction-level reference model.
// Latency: n/a.
// Backpressure: memory responder grants/returns after programmable delays.
module tb_exe_mem_lsu;
    import mips31_pkg::*;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset, ena, flush;
    logic [31:0] exe_instr_in, exe_pc_in, exe_alu_result_in, exe_GPR_rt_in;
    logic        exe_GPR_we_in;
    logic [4:0]  exe_GPR_waddr_in;
    logic [1:0]  exe_GPR_wdata_select_in;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        mem_busy;
    logic [31:0] mem_instr_out, mem_pc_out, mem_alu_result_out, mem_dmem_rdata_out;
    logic        mem_GPR_we;
    logic [4:0]  mem_GPR_waddr;
    logic [1:0]  mem_GPR_wdata_select;
    logic        mem_addr_err, mem_timeout;

    int errors = 0;
    int checks = 0;

    // Reference model of the visible MEM-stage state
    logic [31:0] m_instr, m_pc, m_res, m_rdata;
    logic        m_we, m_to;
    logic [4:0]  m_waddr;
    logic [1:0]  m_sel;

    exe_mem_lsu #(.MAX_WAIT(MAXW), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clk(clk), .reset(reset), .ena(ena), .flush(flush),
        .exe_instr_in(exe_instr_in), .exe_pc_in(exe_pc_in),
        .exe_alu_result_in(exe_alu_result_in), .exe_GPR_rt_in(exe_GPR_rt_in),
        .exe_GPR_we_in(exe_GPR_we_in), .exe_GPR_waddr_in(exe_GPR_waddr_in),
        .exe_GPR_wdata_select_in(exe_GPR_wdata_select_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .mem_busy(mem_busy), .mem_instr_out(mem_instr_out), .mem_pc_out(mem_pc_out),
        .mem_alu_result_out(mem_alu_result_out), .mem_dmem_rdata_out(mem_dmem_rdata_out),
        .mem_GPR_we(mem_GPR_we), .mem_GPR_waddr(mem_GPR_waddr),
        .mem_GPR_wdata_select(mem_GPR_wdata_select),
        .mem_addr_err(mem_addr_err), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_exe(input logic [31:0] ins, pc, addr, rt, input logic we,
                             input logic [4:0] wa, input logic [1:0] sel);
        exe_instr_in = ins; exe_pc_in = pc; exe_alu_result_in = addr; exe_GPR_rt_in = rt;
        exe_GPR_we_in = we; exe_GPR_waddr_in = wa; exe_GPR_wdata_select_in = sel;
    endtask

    task automatic scramble_exe();
        drive_exe($urandom, $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom), 2'($urandom));
    endtask

    // Issue one memory op and play the memory side: gnt in busy cycle g, rvalid r cycles after gnt.
    task automatic mem_access(input logic [31:0] ins, pc, addr, rt, rd, input logic we,
                              input logic [4:0] wa, input logic [1:0] sel, input int g, input int r,
                              output int busy_n, output int req_n, output logic [31:0] a0,
                              output logic [31:0] w0, output logic we0, output bit stable);
        drive_exe(ins, pc, addr, rt, we, wa, sel);
        ena = 1'b1; flush = 1'b0;
        tick();
        scramble_exe();
        busy_n = 0; req_n = 0; stable = 1'b1; a0 = '0; w0 = '0; we0 = 1'b0;
        while (mem_busy && busy_n < 40) begin
            ena = 1'($urandom); flush = 1'($urandom);
            if (dmem_req) begin
                if (req_n == 0) begin
                    a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we;
                end else if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) begin
                    stable = 1'b0;
                end
                req_n++;
            end
            dmem_gnt = (busy_n == g);
            dmem_rvalid = (busy_n == g + r);
            dmem_rdata = dmem_rvalid ? rd : $urandom;
            tick();
            busy_n++;
        end
        ena = 1'b0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    // Transaction-level prediction for a memop with the given delays
    task automatic model_memop(input bit st, input logic [31:0] ins, pc, addr, rd, input logic we,
                               input logic [4:0] wa, input logic [1:0] sel, input int g, input int r,
                               output int exp_busy, output int exp_req);
        int total;
        total = st ? g + 1 : g + 1 + r;
        exp_busy = (total > MAXW) ? MAXW : total;
        exp_req = (g + 1 < exp_busy) ? g + 1 : exp_busy;
        m_instr = ins; m_pc = pc; m_res = addr; m_waddr = wa; m_sel = sel; m_we = 1'b0;
        if (total > MAXW) begin
            m_rdata = 32'hDEADBEEF; m_to = 1'b1;
        end else if (!st) begin
            m_rdata = rd; m_we = we;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ena = 1'b0; flush = 1'b0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        drive_exe('0, '0, '0, '0, 1'b0, '0, '0);
        tick(); tick();
        checks++;
        if ({mem_instr_out, mem_pc_out, mem_alu_result_out, mem_dmem_rdata_out} !== 128'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0",
                {mem_instr_out, mem_pc_out, mem_alu_result_out, mem_dmem_rdata_out});
        end
        checks++;
        if ({mem_busy, dmem_req, mem_GPR_we, mem_GPR_waddr, mem_GPR_wdata_select, mem_addr_err, mem_timeout} !== 12'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 0",
                {mem_busy, dmem_req, mem_GPR_we, mem_GPR_waddr, mem_GPR_wdata_select, mem_addr_err, mem_timeout});
        end
        reset = 1'b0;
        m_instr = '0; m_pc = '0; m_res = '0; m_rdata = '0; m_we = 1'b0; m_to = 1'b0; m_waddr = '0; m_sel = '0;
    endtask

    task automatic test_non_memop();
        logic [31:0] ins;
        ins = {6'b001001, 26'h0A5_0010};
        drive_exe(ins, 32'h0000_0400, 32'h0000_0011, 32'h1, 1'b1, 5'd5, WB_SEL_ALU);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        checks++;
        if (mem_GPR_we !== 1'b1 || mem_GPR_waddr !== 5'd5) begin
            errors++; $display("FAIL nonmem_we: got we=%b waddr=%0d want we=1 waddr=5", mem_GPR_we, mem_GPR_waddr);
        end
        checks++;
        if (mem_busy !== 1'b0 || dmem_req !== 1'b0 || mem_instr_out !== ins) begin
            errors++; $display("FAIL nonmem_idle: got busy=%b req=%b instr=%h want 0 0 %h", mem_busy, dmem_req, mem_instr_out, ins);
        end
        m_instr = ins; m_pc = 32'h400; m_res = 32'h11; m_we = 1'b1; m_waddr = 5'd5; m_sel = WB_SEL_ALU;
    endtask

    task automatic test_store();
        int bn, rn; logic [31:0] a0, w0; logic we0; bit st;
        mem_access({OPC_SW, 26'h0}, 32'h500, 32'h100, 32'hCAFEBABE, 32'h0, 1'b0, 5'd0, WB_SEL_ALU, 3, 0,
                   bn, rn, a0, w0, we0, st);
        checks++;
        if (bn !== 4 || rn !== 4) begin
            errors++; $display("FAIL store_cycles: got busy=%0d req=%0d want 4 4", bn, rn);
        end
        checks++;
        if (a0 !== 32'h100 || w0 !== 32'hCAFEBABE || we0 !== 1'b1 || st !== 1'b1) begin
            errors++; $display("FAIL store_port: got addr=%h wdata=%h we=%b stable=%b want 100 cafebabe 1 1", a0, w0, we0, st);
        end
        checks++;
        if (mem_GPR_we !== 1'b0 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL store_we: got we=%b to=%b want 0 0", mem_GPR_we, mem_timeout);
        end
    endtask

    task automatic test_load();
        int bn, rn; logic [31:0] a0, w0; logic we0; bit st;
        mem_access({OPC_LW, 26'h0}, 32'h504, 32'h40, 32'h0, 32'h12345678, 1'b1, 5'd7, WB_SEL_MEM, 0, 2,
                   bn, rn, a0, w0, we0, st);
        checks++;
        if (mem_dmem_rdata_out !== 32'h12345678 || mem_GPR_we !== 1'b1 || mem_GPR_waddr !== 5'd7) begin
            errors++; $display("FAIL load_data: got rdata=%h we=%b waddr=%0d want 12345678 1 7",
                mem_dmem_rdata_out, mem_GPR_we, mem_GPR_waddr);
        end
        checks++;
        if (bn !== 3 || rn !== 1 || a0 !== 32'h40 || we0 !== 1'b0) begin
            errors++; $display("FAIL load_cycles: got busy=%0d req=%0d addr=%h we=%b want 3 1 40 0", bn, rn, a0, we0);
        end
        checks++;
        if (mem_instr_out !== {OPC_LW, 26'h0} || mem_pc_out !== 32'h504) begin
            errors++; $display("FAIL load_capture_ignores_ena: got instr=%h pc=%h want %h 504",
                mem_instr_out, mem_pc_out, {OPC_LW, 26'h0});
        end
        m_rdata = 32'h12345678;
    endtask

    task automatic test_misaligned();
        drive_exe({OPC_LW, 26'h0}, 32'h508, 32'h41, 32'h0, 1'b1, 5'd9, WB_SEL_MEM);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        checks++;
        if (mem_addr_err !== 1'b1 || mem_busy !== 1'b0 || dmem_req !== 1'b0 || mem_GPR_we !== 1'b0) begin
            errors++; $display("FAIL misalign_pulse: got err=%b busy=%b req=%b we=%b want 1 0 0 0",
                mem_addr_err, mem_busy, dmem_req, mem_GPR_we);
        end
        tick();
        checks++;
        if (mem_addr_err !== 1'b0 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL misalign_clear: got err=%b req=%b want 0 0", mem_addr_err, dmem_req);
        end
    endtask

    task automatic test_flush();
        drive_exe(32'h0123_4567, 32'h600, 32'h77, 32'h5, 1'b1, 5'd3, WB_SEL_PC8);
        ena = 1'b1; flush = 1'b1;
        tick();
        ena = 1'b0; flush = 1'b0;
        checks++;
        if ({mem_instr_out, mem_pc_out, mem_alu_result_out, mem_dmem_rdata_out} !== 128'd0 ||
            {mem_GPR_we, mem_GPR_waddr, mem_GPR_wdata_select} !== 8'd0) begin
            errors++; $display("FAIL flush_bubble: got %h %h %h %h we=%b wa=%0d sel=%0d want all 0",
                mem_instr_out, mem_pc_out, mem_alu_result_out, mem_dmem_rdata_out,
                mem_GPR_we, mem_GPR_waddr, mem_GPR_wdata_select);
        end
        m_instr = '0; m_pc = '0; m_res = '0; m_rdata = '0; m_we = 1'b0; m_waddr = '0; m_sel = '0;
    endtask

    task automatic test_timeout();
        int bn, rn; logic [31:0] a0, w0; logic we0; bit st;
        mem_access({OPC_LW, 26'h0}, 32'h50C, 32'h80, 32'h0, 32'h0, 1'b1, 5'd4, WB_SEL_MEM, 0, 99,
                   bn, rn, a0, w0, we0, st);
        checks++;
        if (bn !== MAXW || mem_dmem_rdata_out !== 32'hDEADBEEF || mem_GPR_we !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got busy=%0d rdata=%h we=%b want %0d deadbeef 0",
                bn, mem_dmem_rdata_out, mem_GPR_we, MAXW);
        end
        tick(); tick(); tick();
        checks++;
        if (mem_timeout !== 1'b1 || mem_busy !== 1'b0) begin
            errors++; $display("FAIL timeout_sticky: got to=%b busy=%b want 1 0", mem_timeout, mem_busy);
        end
    endtask

    task automatic test_reset_in_wait();
        drive_exe({OPC_LW, 26'h0}, 32'h510, 32'hC0, 32'h0, 1'b1, 5'd6, WB_SEL_MEM);
        ena = 1'b1;
        tick();
        ena = 1'b0;
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        checks++;
        if (mem_busy !== 1'b1 || dmem_req !== 1'b0) begin
            errors++; $display("FAIL wait_state: got busy=%b req=%b want 1 0", mem_busy, dmem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({mem_busy, dmem_req, mem_GPR_we, mem_timeout} !== 4'd0 ||
            {mem_instr_out, mem_pc_out, mem_alu_result_out, mem_dmem_rdata_out} !== 128'd0) begin
            errors++; $display("FAIL reset_in_wait: got busy=%b req=%b we=%b to=%b instr=%h rdata=%h want all 0",
                mem_busy, dmem_req, mem_GPR_we, mem_timeout, mem_instr_out, mem_dmem_rdata_out);
        end
        dmem_rvalid = 1'b1; dmem_rdata = 32'hABCD_0123;
        tick();
        dmem_rvalid = 1'b0;
        tick();
        checks++;
        if (mem_GPR_we !== 1'b0 || mem_dmem_rdata_out !== 32'd0 || mem_busy !== 1'b0) begin
            errors++; $display("FAIL late_rvalid: got we=%b rdata=%h busy=%b want 0 0 0",
                mem_GPR_we, mem_dmem_rdata_out, mem_busy);
        end
        m_instr = '0; m_pc = '0; m_res = '0; m_rdata = '0; m_we = 1'b0; m_to = 1'b0; m_waddr = '0; m_sel = '0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 80; it++) begin
            int kind, g, r, bn, rn, eb, er;
            logic [31:0] ins, pc, addr, rt, rd, a0, w0;
            logic we, we0, exp_err;
            logic [4:0] wa;
            logic [1:0] sel;
            bit st;
            kind = $urandom_range(0, 5);
            ins = $urandom; pc = $urandom; addr = $urandom; rt = $urandom; rd = $urandom;
            we = 1'($urandom); wa = 5'($urandom); sel = 2'($urandom);
            g = $urandom_range(0, 3); r = $urandom_range(0, 3);
            exp_err = 1'b0;
            if (kind == 0) ins[31] = 1'b0;
            if (kind == 1) begin ins[31:26] = OPC_LW; addr[1:0] = 2'b00; end
            if (kind == 2) begin ins[31:26] = OPC_SW; addr[1:0] = 2'b00; end
            if (kind == 3) begin ins[31] = 1'b1; addr[1:0] = 2'($urandom_range(1, 3)); end
            if (kind == 1 || kind == 2) begin
                mem_access(ins, pc, addr, rt, rd, we, wa, sel, g, r, bn, rn, a0, w0, we0, st);
                model_memop(kind == 2, ins, pc, addr, rd, we, wa, sel, g, r, eb, er);
                checks++;
                if (bn !== eb || rn !== er) begin
                    errors++; $display("FAIL rand_cycles[%0d]: got busy=%0d req=%0d want %0d %0d", it, bn, rn, eb, er);
                end
                checks++;
                if (a0 !== addr || w0 !== rt || we0 !== (kind == 2) || st !== 1'b1) begin
                    errors++; $display("FAIL rand_port[%0d]: got addr=%h wdata=%h we=%b stable=%b want %h %h %b 1",
                        it, a0, w0, we0, st, addr, rt, kind == 2);
                end
            end else if (kind == 0 || kind == 3) begin
                drive_exe(ins, pc, addr, rt, we, wa, sel);
                ena = 1'b1; flush = 1'b0;
                tick();
                ena = 1'b0;
                m_instr = ins; m_pc = pc; m_res = addr; m_waddr = wa; m_sel = sel;
                m_we = (kind == 0) ? we : 1'b0;
                exp_err = (kind == 3);
            end else if (kind == 4) begin
                scramble_exe();
                ena = 1'b0; flush = 1'b0;
                tick();
            end else begin
                scramble_exe();
                ena = 1'($urandom); flush = 1'b1;
                tick();
                ena = 1'b0; flush = 1'b0;
                m_instr = '0; m_pc = '0; m_res = '0; m_rdata = '0; m_we = 1'b0; m_waddr = '0; m_sel = '0;
            end
            checks++;
            if ({mem_instr_out, mem_pc_out, mem_alu_result_out, mem_dmem_rdata_out,
                 mem_GPR_we, mem_GPR_waddr, mem_GPR_wdata_select, mem_timeout} !==
                {m_instr, m_pc, m_res, m_rdata, m_we, m_waddr, m_sel, m_to}) begin
                errors++; $display("FAIL rand_state[%0d] kind=%0d: got %h %h %h %h %b %0d %0d %b want %h %h %h %h %b %0d %0d %b",
                    it, kind, mem_instr_out, mem_pc_out, mem_alu_result_out, mem_dmem_rdata_out,
                    mem_GPR_we, mem_GPR_waddr, mem_GPR_wdata_select, mem_timeout,
                    m_instr, m_pc, m_res, m_rdata, m_we, m_waddr, m_sel, m_to);
            end
            checks++;
            if (mem_addr_err !== exp_err || mem_busy !== 1'b0 || dmem_req !== 1'b0) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got err=%b busy=%b req=%b want %b 0 0",
                    it, mem_addr_err, mem_busy, dmem_req, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_non_memop();
        test_store();
        test_load();
        test_misaligned();
        test_flush();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
